// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// datapath mux selects and the bundled control-word type.
package mips_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExec    = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11
  } state_e;

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpJ     = 6'h02;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_beq;
    logic       pc_write_bne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dest;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;
    logic       mem_fault;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op, input logic bne_en);
    case (op)
      OpRType, OpAddi, OpBeq, OpLw, OpSw, OpJ: op_legal = 1'b1;
      OpBne:                                   op_legal = bne_en;
      default:                                 op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for memory states; restarts from zero whenever the FSM
// is not holding in a memory state, so every state entry starts a fresh count.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  output logic timeout
);

  localparam logic [7:0] Limit = 8'(TIMEOUT);

  logic [7:0] count_q, count_d;

  assign count_d = hold ? count_q + 8'd1 : 8'd0;
  assign timeout = (count_q == Limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: one state register, combinational next-state and
// control-word decode, plus a memory wait timer that aborts stalled accesses.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned MEM_TIMEOUT   = 15,
  parameter int unsigned ENABLE_BNE    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_beq,
  output logic       pc_write_bne,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dest,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       mem_fault
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   mem_state, mem_done, timeout, hold, bne_en;

  assign bne_en    = (ENABLE_BNE != 0);
  assign mem_state = state_q inside {StFetch, StMemRd, StMemWr};
  assign mem_done  = (MEM_HANDSHAKE == 0) || mem_ready;
  // mem_done wins over timeout so a late-but-in-time access still completes.
  assign hold      = mem_state && !mem_done && !timeout;

  mem_wait_timer #(
    .TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (hold),
    .timeout(timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (mem_done) state_d = StDecode;
      end
      StDecode: begin
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRType:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpBne:      state_d = bne_en ? StBranch : StFetch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd: begin
        if (mem_done)     state_d = StMemWb;
        else if (timeout) state_d = StFetch;
      end
      StMemWr: begin
        if (mem_done || timeout) state_d = StFetch;
      end
      StExec:   state_d = StAluWb;
      StAddiEx: state_d = StAddiWb;
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SrcBFour;
        ctrl.ir_write  = mem_done;
        ctrl.pc_write  = mem_done;
      end
      StDecode: begin
        ctrl.alu_src_b  = SrcBImmSh;
        ctrl.illegal_op = !op_legal(opcode, bne_en);
      end
      StMemAdr, StAddiEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBImm;
      end
      StMemRd: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      StMemWr: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      StExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = AluFunct;
      end
      StAluWb: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dest  = 1'b1;
      end
      StAddiWb: ctrl.reg_write = 1'b1;
      StBranch: begin
        ctrl.alu_src_a    = 1'b1;
        ctrl.alu_op       = AluSub;
        ctrl.pc_src       = PcAluOut;
        ctrl.pc_write_beq = (opcode == OpBeq);
        ctrl.pc_write_bne = (opcode == OpBne) && bne_en;
      end
      StJump: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PcJump;
      end
      default: ctrl = '0;
    endcase
    ctrl.mem_fault = mem_state && !mem_done && timeout;
    // Nothing may strobe while reset is held, even mid-instruction.
    if (!rst_n) ctrl = '0;
  end

  assign pc_write     = ctrl.pc_write;
  assign pc_write_beq = ctrl.pc_write_beq;
  assign pc_write_bne = ctrl.pc_write_bne;
  assign iord         = ctrl.iord;
  assign mem_read     = ctrl.mem_read;
  assign mem_write    = ctrl.mem_write;
  assign ir_write     = ctrl.ir_write;
  assign mem_to_reg   = ctrl.mem_to_reg;
  assign reg_dest     = ctrl.reg_dest;
  assign reg_write    = ctrl.reg_write;
  assign alu_src_a    = ctrl.alu_src_a;
  assign alu_src_b    = ctrl.alu_src_b;
  assign alu_op       = ctrl.alu_op;
  assign pc_src       = ctrl.pc_src;
  assign illegal_op   = ctrl.illegal_op;
  assign mem_fault    = ctrl.mem_fault;
  assign state        = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: three parameterisations share one input stream
// and are compared every cycle against an instruction-route reference model.
`timescale 1ns/1ps
module tb_multicycle_control;

  localparam int NCfg = 3;
  localparam int HS [NCfg] = '{1, 0, 1};
  localparam int TO [NCfg] = '{15, 15, 4};
  localparam int EB [NCfg] = '{1, 1, 0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;

  logic       pc_write [NCfg];
  logic       pc_write_beq [NCfg];
  logic       pc_write_bne [NCfg];
  logic       iord [NCfg];
  logic       mem_read [NCfg];
  logic       mem_write [NCfg];
  logic       ir_write [NCfg];
  logic       mem_to_reg [NCfg];
  logic       reg_dest [NCfg];
  logic       reg_write [NCfg];
  logic       alu_src_a [NCfg];
  logic [1:0] alu_src_b [NCfg];
  logic [1:0] alu_op [NCfg];
  logic [1:0] pc_src [NCfg];
  logic [3:0] state [NCfg];
  logic       illegal_op [NCfg];
  logic       mem_fault [NCfg];

  for (genvar g = 0; g < NCfg; g++) begin : g_dut
    multicycle_control #(
      .MEM_HANDSHAKE(HS[g]),
      .MEM_TIMEOUT  (TO[g]),
      .ENABLE_BNE   (EB[g])
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .opcode      (opcode),
      .mem_ready   (mem_ready),
      .pc_write    (pc_write[g]),
      .pc_write_beq(pc_write_beq[g]),
      .pc_write_bne(pc_write_bne[g]),
      .iord        (iord[g]),
      .mem_read    (mem_read[g]),
      .mem_write   (mem_write[g]),
      .ir_write    (ir_write[g]),
      .mem_to_reg  (mem_to_reg[g]),
      .reg_dest    (reg_dest[g]),
      .reg_write   (reg_write[g]),
      .alu_src_a   (alu_src_a[g]),
      .alu_src_b   (alu_src_b[g]),
      .alu_op      (alu_op[g]),
      .pc_src      (pc_src[g]),
      .state       (state[g]),
      .illegal_op  (illegal_op[g]),
      .mem_fault   (mem_fault[g])
    );
  end

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int mst [NCfg];
  int mcnt [NCfg];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [22:0] dut_vec(input int c);
    return {pc_write[c], pc_write_beq[c], pc_write_bne[c], iord[c], mem_read[c], mem_write[c],
            ir_write[c], mem_to_reg[c], reg_dest[c], reg_write[c], alu_src_a[c], alu_src_b[c],
            alu_op[c], pc_src[c], state[c], illegal_op[c], mem_fault[c]};
  endfunction

  function automatic bit legal(input int c, input logic [5:0] op);
    case (op)
      6'h00, 6'h08, 6'h04, 6'h23, 6'h2B, 6'h02: return 1'b1;
      6'h05:                                    return EB[c] != 0;
      default:                                  return 1'b0;
    endcase
  endfunction

  function automatic bit is_mem(input int s);
    return s == 0 || s == 3 || s == 5;
  endfunction

  // The instruction's whole state route is chosen from the opcode; the model
  // simply steps along it.
  function automatic int route_next(input int c, input logic [5:0] op, input int s);
    int r [5];
    int len;
    r = '{0, 1, 0, 0, 0};
    len = 2;
    if (legal(c, op)) begin
      case (op)
        6'h00:        begin r = '{0, 1, 6, 7, 0};  len = 4; end
        6'h08:        begin r = '{0, 1, 9, 10, 0}; len = 4; end
        6'h04, 6'h05: begin r = '{0, 1, 8, 0, 0};  len = 3; end
        6'h23:        begin r = '{0, 1, 2, 3, 4};  len = 5; end
        6'h2B:        begin r = '{0, 1, 2, 5, 0};  len = 4; end
        6'h02:        begin r = '{0, 1, 11, 0, 0}; len = 3; end
        default:      len = 2;
      endcase
    end
    for (int i = 0; i < len - 1; i++) if (r[i] == s) return r[i + 1];
    return 0;
  endfunction

  function automatic logic [22:0] model_out(input int c, input logic [5:0] op, input logic rdy);
    logic pw, beq, bne, io, mr, mw, irw, m2r, rd, rw, asa, ill, flt;
    logic [1:0] asb, aop, psrc;
    bit done;
    int s;
    s = mst[c];
    done = (HS[c] == 0) || rdy;
    {pw, beq, bne, io, mr, mw, irw, m2r, rd, rw, asa, ill, flt} = '0;
    asb = 2'd0; aop = 2'd0; psrc = 2'd0;
    flt = is_mem(s) && !done && (mcnt[c] == TO[c]);
    case (s)
      0:    begin mr = 1; asb = 2'd1; irw = done; pw = done; end
      1:    begin asb = 2'd3; ill = !legal(c, op); end
      2, 9: begin asa = 1; asb = 2'd2; end
      3:    begin mr = 1; io = 1; end
      4:    begin rw = 1; m2r = 1; end
      5:    begin mw = 1; io = 1; end
      6:    begin asa = 1; aop = 2'd2; end
      7:    begin rw = 1; rd = 1; end
      8:    begin asa = 1; aop = 2'd1; psrc = 2'd1; beq = (op == 6'h04); bne = (op == 6'h05); end
      10:   rw = 1;
      11:   begin pw = 1; psrc = 2'd2; end
      default: ;
    endcase
    return {pw, beq, bne, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, 4'(s), ill, flt};
  endfunction

  task automatic model_advance(input int c, input logic [5:0] op, input logic rdy);
    bit done;
    bit expired;
    done = (HS[c] == 0) || rdy;
    expired = mcnt[c] == TO[c];
    if (is_mem(mst[c]) && !done) begin
      mst[c] = expired ? 0 : mst[c];
      mcnt[c] = expired ? 0 : mcnt[c] + 1;
    end else begin
      mst[c] = route_next(c, op, mst[c]);
      mcnt[c] = 0;
    end
  endtask

  // One clock cycle: drive at negedge, sample just before the rising edge.
  task automatic step(input logic [5:0] op, input logic rdy);
    @(negedge clk);
    opcode = op;
    mem_ready = rdy;
    #4;
    for (int c = 0; c < NCfg; c++) begin
      check($sformatf("cfg%0d_cycle st%0d", c, mst[c]), 32'(dut_vec(c)), 32'(model_out(c, op, rdy)));
      model_advance(c, op, rdy);
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < NCfg; c++) check($sformatf("%s_rst_cfg%0d", tag, c), 32'(dut_vec(c)), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < NCfg; c++) begin
      mst[c] = 0;
      mcnt[c] = 0;
    end
  endtask

  initial begin
    int rt_seq [5];
    int cnt_a, cnt_b, fault_at;
    logic [5:0] op;
    logic [5:0] ops [8];

    opcode = 6'h00;
    mem_ready = 1'b0;
    do_reset("init");

    // R-type on the no-handshake instance: 0,1,6,7,0.
    rt_seq = '{0, 1, 6, 7, 0};
    for (int k = 0; k < 5; k++) begin
      step(6'h00, 1'b0);
      check("rtype_state", 32'(state[1]), 32'(rt_seq[k]));
      check("rtype_wb", 32'({reg_write[1], reg_dest[1]}), (k == 3) ? 32'd3 : 32'd0);
    end

    // LW with mem_ready three cycles late in FETCH and MEM_RD.
    do_reset("lw");
    cnt_a = 0;
    cnt_b = 0;
    for (int k = 1; k <= 11; k++) begin
      step(6'h23, (k == 4) || (k == 10));
      if (state[0] == 4'd0) cnt_a++;
      if (ir_write[0]) cnt_b++;
    end
    check("lw_fetch_len", 32'(cnt_a), 32'd4);
    check("lw_ir_write", 32'(cnt_b), 32'd1);
    check("lw_end_memwb", 32'({state[0], mem_to_reg[0]}), 32'({4'd4, 1'b1}));

    // BNE, supported vs. disabled.
    do_reset("bne");
    step(6'h05, 1'b1);
    step(6'h05, 1'b1);
    check("bne_dis_illegal", 32'(illegal_op[2]), 32'd1);
    check("bne_en_legal", 32'(illegal_op[0]), 32'd0);
    step(6'h05, 1'b1);
    check("bne_branch_strobes", 32'({state[0], pc_write_beq[0], pc_write_bne[0]}),
          32'({4'd8, 1'b0, 1'b1}));
    check("bne_dis_fetch", 32'(state[2]), 32'd0);

    // Illegal opcode 0x3F.
    do_reset("ill");
    cnt_a = 0;
    cnt_b = 0;
    for (int k = 1; k <= 3; k++) begin
      step(6'h3F, 1'b1);
      if (illegal_op[0]) cnt_a++;
      if (reg_write[0] || mem_write[0]) cnt_b++;
    end
    check("ill_pulses", 32'(cnt_a), 32'd1);
    check("ill_writes", 32'(cnt_b), 32'd0);
    check("ill_back_fetch", 32'(state[0]), 32'd0);

    // SW with mem_ready stuck low: fault on the 16th MEM_WR cycle (count 15).
    do_reset("sw_to");
    fault_at = -1;
    for (int k = 1; k <= 20; k++) begin
      step(6'h2B, k == 1);
      if (mem_fault[0] && fault_at < 0) fault_at = k;
    end
    check("sw_fault_cycle", 32'(fault_at), 32'd19);
    check("sw_fault_fetch", 32'(state[0]), 32'd0);

    // SW where mem_ready lands on the timeout cycle: completes, no fault.
    do_reset("sw_ok");
    cnt_a = 0;
    for (int k = 1; k <= 20; k++) begin
      step(6'h2B, (k == 1) || (k == 19));
      if (mem_fault[0]) cnt_a++;
      if (k == 19) check("sw_late_write", 32'({state[0], mem_write[0]}), 32'({4'd5, 1'b1}));
    end
    check("sw_late_nofault", 32'(cnt_a), 32'd0);

    // Asynchronous reset in the middle of MEM_WR.
    do_reset("arst_pre");
    step(6'h2B, 1'b1);
    for (int k = 0; k < 4; k++) step(6'h2B, 1'b0);
    @(negedge clk);
    #1;
    check("arst_mw_before", 32'({state[0], mem_write[0]}), 32'({4'd5, 1'b1}));
    rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state[0]), 32'd0);
    check("arst_mem_write", 32'(mem_write[0]), 32'd0);
    do_reset("arst");

    // Random instruction stream; opcode only changes while every instance fetches.
    ops = '{6'h00, 6'h08, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h02, 6'h00};
    op = 6'h00;
    for (int i = 0; i < 3000; i++) begin
      if (mst[0] == 0 && mst[1] == 0 && mst[2] == 0 && $urandom_range(0, 1) == 1) begin
        op = ops[$urandom_range(0, 7)];
        if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 399) == 0) do_reset("rand");
      step(op, $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL provide parameter MEM_HANDSHAKE, default 1: 1 = memory states wait for mem_ready; 0 = memory assumed single-cycle, mem_ready ignored.
REQ-002 SHALL provide parameter MEM_TIMEOUT, default 15, range 1-255: maximum wait cycles in any memory state before a fault.
REQ-003 SHALL provide parameter ENABLE_BNE, default 1: 1 = BNE supported; 0 = BNE treated as illegal.
REQ-004 SHALL have port list (name direction width meaning): clk in 1 sole clock, rising edge; rst_n in 1 asynchronous active-low reset.
REQ-005 SHALL have opcode in 6 (instruction register opcode, valid from DECODE onward) and mem_ready in 1 (memory access complete this cycle).
REQ-006 SHALL have outputs pc_write, pc_write_beq, pc_write_bne, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dest, reg_write, alu_src_a, each 1 bit.
REQ-007 SHALL have outputs alu_src_b 2 (00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2), alu_op 2 (00 add, 01 sub, 10 funct), pc_src 2 (00 ALU, 01 ALUOut, 10 jump target).
REQ-008 SHALL have outputs state 4 (debug current state), illegal_op 1 (one-cycle pulse), mem_fault 1 (one-cycle pulse).

Function
REQ-009 SHALL implement states FETCH=0, DECODE=1, MEM_ADR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, ALU_WB=7, BRANCH=8, ADDI_EX=9, ADDI_WB=10, JUMP=11; codes 12-15 unreachable and SHALL return to FETCH.
REQ-010 SHALL decode opcodes 0x00 R-type, 0x08 ADDI, 0x04 BEQ, 0x05 BNE, 0x23 LW, 0x2B SW, 0x02 J; all other opcodes are illegal.
REQ-011 SHALL transition: DECODE -> MEM_ADR (LW/SW), EXEC (R), BRANCH (BEQ/BNE), ADDI_EX, JUMP; MEM_ADR -> MEM_RD (LW) or MEM_WR (SW); MEM_RD -> MEM_WB; EXEC -> ALU_WB; ADDI_EX -> ADDI_WB; MEM_WB, MEM_WR, ALU_WB, ADDI_WB, BRANCH, JUMP -> FETCH.
REQ-012 SHALL treat FETCH, MEM_RD, MEM_WR as memory states: with MEM_HANDSHAKE=1 each holds until mem_ready=1, then advances; with MEM_HANDSHAKE=0 each lasts one cycle.
REQ-013 SHALL in FETCH assert mem_read, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, and assert ir_write and pc_write only in the cycle the access completes (mem_ready, or always if MEM_HANDSHAKE=0).
REQ-014 SHALL in DECODE drive alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
REQ-015 SHALL in MEM_ADR and ADDI_EX drive alu_src_a=1, alu_src_b=10, alu_op=00; MEM_RD: mem_read=1, iord=1; MEM_WR: mem_write=1, iord=1; MEM_WB: reg_write=1, mem_to_reg=1, reg_dest=0.
REQ-016 SHALL in EXEC drive alu_src_a=1, alu_src_b=00, alu_op=10; ALU_WB: reg_write=1, reg_dest=1, mem_to_reg=0; ADDI_WB: reg_write=1, reg_dest=0, mem_to_reg=0.
REQ-017 SHALL in BRANCH drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, with pc_write_beq=1 for BEQ or pc_write_bne=1 for BNE, never both.
REQ-018 SHALL in JUMP drive pc_write=1 and pc_src=10.
REQ-019 SHALL drive every output not listed for a state to 0.
REQ-020 SHALL in DECODE with an illegal opcode pulse illegal_op for that cycle and go to FETCH with no register or memory write.
REQ-021 SHALL count wait cycles in a memory state with an 8-bit counter cleared on state entry; when the count reaches MEM_TIMEOUT with no mem_ready it SHALL pulse mem_fault and go to FETCH without asserting ir_write, pc_write, or reg_write.
REQ-022 SHALL give mem_ready priority when mem_ready=1 arrives in the same cycle as the timeout, so the access completes normally.

Reset
REQ-023 SHALL on rst_n=0, asynchronously, set state=FETCH, clear the wait counter, and deassert all pulse outputs; the first fetch begins on the first clock edge with rst_n=1.
REQ-024 SHALL on reset asserted mid-instruction abandon the instruction with no further write strobes.

Structure
REQ-025 SHALL place the state encodings, opcode constants, and alu_op/alu_src_b/pc_src encodings in shared package mips_pkg.
REQ-026 SHALL contain a single sub-module, mem_wait_timer (counter, timeout compare), with all other logic in one state register plus combinational next-state/output decode.

Verification
REQ-027 SHALL verify R-type with MEM_HANDSHAKE=0, opcode 0x00: states 0,1,6,7,0 over 4 cycles, and reg_write=1 with reg_dest=1 only in ALU_WB.
REQ-028 SHALL verify LW with mem_ready late by 3 cycles in FETCH and MEM_RD: FETCH lasts 4 cycles with ir_write once, and the total is 5+6=11 cycles ending in MEM_WB with mem_to_reg=1.
REQ-029 SHALL verify BNE with ENABLE_BNE=1: pc_write_bne=1 and pc_write_beq=0 in BRANCH; with ENABLE_BNE=0, illegal_op pulses in DECODE and the next state is FETCH.
REQ-030 SHALL verify opcode 0x3F: one illegal_op pulse and no reg_write or mem_write for the whole instruction.
REQ-031 SHALL verify SW with mem_ready held at 0 and MEM_TIMEOUT=15: mem_fault pulses after 15 wait cycles in MEM_WR, then FETCH; with mem_ready=1 on cycle 15, mem_write completes and there is no fault.
REQ-032 SHALL verify rst_n asserted in MEM_WR: state=0 and mem_write=0 immediately, before the next clock edge.
